i_prefetch: RTL and testbench

Instruction prefetch controller between the CPU fetch stage and the instruction memory (`i_mem_tang`). It issues sequential single-byte reads over the memory's `i_req`/`i_ack` handshake and buffers fetched opcodes in a small FIFO. The CPU pops opcodes through its own req/ack port. A CPU jump (loop `[`/`]` target) flushes the buffer and restarts fetching at the new address.

---
 rtl/i_prefetch_pkg.sv | 20 ++
 rtl/i_prefetch_if.sv | 27 ++
 rtl/i_prefetch_fifo.sv | 64 ++++++
 rtl/i_prefetch.sv | 105 ++++++++++
 tb/tb_i_prefetch.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i_prefetch_pkg.sv
// Shared definitions for the instruction prefetch controller: FSM state
// encoding and the width of one buffered FIFO entry ({address, opcode}).
package i_prefetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_GAP   = ST_GAP
  } state_e;

  // One FIFO entry carries the opcode address above the 8-bit opcode.
  function automatic int entry_width(input int addr_width);
    return addr_width + 8;
  endfunction

endpackage

// File: rtl/i_prefetch_if.sv
// Bus bundle for the prefetch controller: CPU pop/jump port and the
// instruction-memory req/ack read port. "master" is the prefetcher view,
// "slave" is the view of the CPU + memory side it talks to.
interface i_prefetch_if #(
  parameter int i_addr_width = 16
);
  logic                    c_req;
  logic                    c_ack;
  logic [7:0]              c_rdata;
  logic [i_addr_width-1:0] c_pc;
  logic                    c_jump;
  logic [i_addr_width-1:0] c_jump_addr;
  logic                    i_req;
  logic [i_addr_width-1:0] i_addr;
  logic                    i_ack;
  logic [7:0]              i_rdata;

  modport master (
    input  c_req, c_jump, c_jump_addr, i_ack, i_rdata,
    output c_ack, c_rdata, c_pc, i_req, i_addr
  );

  modport slave (
    output c_req, c_jump, c_jump_addr, i_ack, i_rdata,
    input  c_ack, c_rdata, c_pc, i_req, i_addr
  );
endinterface

// File: rtl/i_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched {address, opcode} entries.
// Head entry is read combinationally so a pushed byte is visible the next
// cycle; head reads as zero while empty. Flush beats push and pop.
module i_prefetch_fifo
  import i_prefetch_pkg::*;
#(
  parameter int width = entry_width(16),
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [width-1:0]         wdata_i,
  output logic [width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(depth):0]   count_o
);
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(depth));
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/i_prefetch.sv
// Instruction prefetch controller: issues single-byte sequential reads to
// the instruction memory (one outstanding, with a one-cycle request gap so
// the memory's ready flag clears), buffers opcodes in a FIFO and hands them
// to the CPU. A CPU jump flushes the buffer and restarts at the target.
// Optional build macro I_PREFETCH_WRAP_EN: fetch address wraps from
// i_mem_length-1 back to 0 instead of stopping at the end of the program.
module i_prefetch
  import i_prefetch_pkg::*;
#(
  parameter int i_addr_width = 16,
  parameter int i_mem_length = 256,
  parameter int depth        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  i_prefetch_if.master  bus
);
  localparam int EW  = entry_width(i_addr_width);
  localparam int AW1 = i_addr_width + 1;
  localparam int CW  = $clog2(depth) + 1;
  // One extra address bit so "fetch_addr == i_mem_length" is representable
  // even when the program fills the whole address space.
  localparam logic [AW1-1:0] MEM_LEN  = AW1'(i_mem_length);
  localparam logic [AW1-1:0] MEM_LAST = AW1'(i_mem_length - 1);

  state_e           state_q, state_d;
  logic [AW1-1:0]   fetch_addr_q, fetch_addr_d;
  logic [AW1-1:0]   next_addr;
  logic             can_fetch;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;

`ifdef I_PREFETCH_WRAP_EN
  assign next_addr = (fetch_addr_q == MEM_LAST) ? '0 : fetch_addr_q + 1'b1;
`else
  assign next_addr = fetch_addr_q + 1'b1;
`endif

  // Room for one more byte and still inside the program image.
  assign can_fetch = (fifo_count < CW'(depth)) && (fetch_addr_q < MEM_LEN);

  // Next-state logic: single outstanding read, jump overrides everything.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    push         = 1'b0;
    case (state_q)
      S_IDLE:  if (can_fetch) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.i_ack) begin
          push         = ~fifo_full;
          fetch_addr_d = next_addr;
          state_d      = S_GAP;
        end
      end
      S_GAP:   state_d = can_fetch ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.c_jump) begin
      state_d      = S_GAP;
      fetch_addr_d = {1'b0, bus.c_jump_addr};
      push         = 1'b0;
    end
  end

  // State and fetch-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign bus.i_req   = (state_q == S_FETCH);
  assign bus.i_addr  = bus.i_req ? fetch_addr_q[i_addr_width-1:0] : '0;

  assign pop         = bus.c_req & ~fifo_empty & ~bus.c_jump;
  assign bus.c_ack   = pop;
  assign bus.c_rdata = head[7:0];
  assign bus.c_pc    = head[EW-1:8];

  i_prefetch_fifo #(
    .width (EW),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.c_jump),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({fetch_addr_q[i_addr_width-1:0], bus.i_rdata}),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_i_prefetch.sv
// Bench for i_prefetch: behavioural instruction memory (ack one cycle after
// req rises, drops when req falls), scoreboard of expected {pc, opcode}
// pushed on each accepted fetch and popped on every c_ack, plus per-scenario
// timing checks. Honours I_PREFETCH_WRAP_EN the same way the design does.
module tb_i_prefetch;
  localparam int AW      = 16;
  localparam int MEM_LEN = 72;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i_prefetch_if #(.i_addr_width(AW)) bus ();

  i_prefetch #(
    .i_addr_width (AW),
    .i_mem_length (MEM_LEN),
    .depth        (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]      mem [256];
  logic            ack_q;
  logic [AW+7:0]   sb [$];
  logic [AW-1:0]   exp_addr;
  int              pop_count = 0;
  bit              saw_last = 0;
  bit              saw_wrap = 0;

  // Memory model: ready flag rises one cycle after req, clears when req drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= bus.i_req & ~ack_q;
  end
  assign bus.i_ack   = ack_q;
  assign bus.i_rdata = ack_q ? mem[bus.i_addr[7:0]] : 8'h00;

  // Scoreboard: pop-compare on c_ack, then push on each accepted fetch.
  initial begin
    logic [AW+7:0] e;
    exp_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_addr = '0;
      end else begin
        if (bus.c_ack) begin
          pop_count++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_pop: c_ack with pc=%h data=%h but nothing expected", bus.c_pc, bus.c_rdata);
          end else begin
            e = sb.pop_front();
            if ({bus.c_pc, bus.c_rdata} !== e) begin
              errors++;
              $display("FAIL sb_data: got pc=%h data=%h expected pc=%h data=%h",
                       bus.c_pc, bus.c_rdata, e[AW+7:8], e[7:0]);
            end else
              $display("pop  pc=%h data=%h ok", bus.c_pc, bus.c_rdata);
          end
        end
        if (bus.c_jump) begin
          sb.delete();
          exp_addr = bus.c_jump_addr;
          $display("jump to %h", bus.c_jump_addr);
        end else if (bus.i_req && bus.i_ack) begin
          checks++;
          if (bus.i_addr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_addr: got %h expected %h", bus.i_addr, exp_addr);
          end
          sb.push_back({exp_addr, mem[exp_addr[7:0]]});
          $display("fetch addr=%h data=%h", bus.i_addr, bus.i_rdata);
          if (exp_addr == AW'(MEM_LEN - 1)) saw_last = 1;
          else if (exp_addr == '0 && saw_last) saw_wrap = 1;
`ifdef I_PREFETCH_WRAP_EN
          exp_addr = (exp_addr == AW'(MEM_LEN - 1)) ? '0 : exp_addr + 1'b1;
`else
          exp_addr = exp_addr + 1'b1;
`endif
        end
      end
    end
  end

  task automatic apply_reset(input logic req);
    rst_n = 1'b0;
    bus.c_req = req;
    bus.c_jump = 1'b0;
    bus.c_jump_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.c_req = 1'b1;
    bus.c_jump = 1'b0;
    bus.c_jump_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.i_req !== 1'b0)   begin errors++; $display("FAIL reset_i_req: got %b want 0", bus.i_req); end
    checks++; if (bus.i_addr !== '0)    begin errors++; $display("FAIL reset_i_addr: got %h want 0", bus.i_addr); end
    checks++; if (bus.c_ack !== 1'b0)   begin errors++; $display("FAIL reset_c_ack: got %b want 0", bus.c_ack); end
    checks++; if (bus.c_rdata !== 8'h0) begin errors++; $display("FAIL reset_c_rdata: got %h want 0", bus.c_rdata); end
    checks++; if (bus.c_pc !== '0)      begin errors++; $display("FAIL reset_c_pc: got %h want 0", bus.c_pc); end
    $display("test_reset done");
  endtask

  task automatic test_sequential;
    apply_reset(1'b1);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      case (k)
        0: begin checks++; if (bus.i_req !== 1'b0) begin errors++; $display("FAIL seq_c0_i_req: got %b want 0", bus.i_req); end end
        1: begin checks++; if (bus.i_req !== 1'b1 || bus.i_addr !== 16'h0) begin errors++; $display("FAIL seq_c1_req: got req=%b addr=%h want 1/0000", bus.i_req, bus.i_addr); end end
        2: begin checks++; if (bus.i_ack !== 1'b1 || bus.c_ack !== 1'b0) begin errors++; $display("FAIL seq_c2: got i_ack=%b c_ack=%b want 1/0", bus.i_ack, bus.c_ack); end end
        3: begin checks++; if (bus.c_ack !== 1'b1 || bus.c_rdata !== 8'h2B || bus.c_pc !== 16'h0) begin errors++; $display("FAIL seq_c3: got ack=%b data=%h pc=%h want 1/2b/0000", bus.c_ack, bus.c_rdata, bus.c_pc); end end
        4, 5: begin checks++; if (bus.c_ack !== 1'b0) begin errors++; $display("FAIL seq_c%0d_gap: got c_ack=%b want 0", k, bus.c_ack); end end
        6: begin checks++; if (bus.c_ack !== 1'b1 || bus.c_rdata !== 8'h3E || bus.c_pc !== 16'h1) begin errors++; $display("FAIL seq_c6: got ack=%b data=%h pc=%h want 1/3e/0001", bus.c_ack, bus.c_rdata, bus.c_pc); end end
        default: ;
      endcase
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1 bus.c_req = 1'b0;
    $display("test_sequential done");
  endtask

  task automatic test_fill_drain;
    int fetches = 0;
    int acks = 0;
    bit seen_req = 0;
    apply_reset(1'b0);
    repeat (30) begin
      @(negedge clk);
      if (bus.i_req && bus.i_ack) fetches++;
    end
    checks++; if (fetches != DEPTH) begin errors++; $display("FAIL fill_count: got %0d fetches want %0d", fetches, DEPTH); end
    checks++; if (bus.i_req !== 1'b0) begin errors++; $display("FAIL fill_idle: got i_req=%b want 0", bus.i_req); end
    checks++; if (bus.c_rdata !== 8'h2B || bus.c_pc !== 16'h0) begin errors++; $display("FAIL fill_head: got data=%h pc=%h want 2b/0000", bus.c_rdata, bus.c_pc); end
    @(posedge clk); #1 bus.c_req = 1'b1;
    repeat (DEPTH) begin
      @(negedge clk);
      if (bus.c_ack) acks++;
      if (bus.i_req) seen_req = 1;
    end
    checks++; if (acks != DEPTH) begin errors++; $display("FAIL drain_b2b: got %0d acks in %0d cycles want %0d", acks, DEPTH, DEPTH); end
    checks++; if (!seen_req) begin errors++; $display("FAIL drain_refetch: got no i_req while draining want i_req=1"); end
    @(posedge clk); #1 bus.c_req = 1'b0;
    repeat (20) @(negedge clk);
    $display("test_fill_drain done");
  endtask

  task automatic test_jump;
    bit found = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.i_req && !bus.i_ack && bus.i_addr == 16'h2) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL jump_wait: got no fetch of addr 0002 within 30 cycles"); end
    @(posedge clk); #1;
    bus.c_jump = 1'b1; bus.c_jump_addr = 16'h0040; bus.c_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.i_ack !== 1'b1 || bus.c_ack !== 1'b0) begin errors++; $display("FAIL jump_cJ: got i_ack=%b c_ack=%b want 1/0", bus.i_ack, bus.c_ack); end
    @(posedge clk); #1 bus.c_jump = 1'b0;
    @(negedge clk);
    checks++; if (bus.i_req !== 1'b0 || bus.c_ack !== 1'b0) begin errors++; $display("FAIL jump_J1: got i_req=%b c_ack=%b want 0/0", bus.i_req, bus.c_ack); end
    @(negedge clk);
    checks++; if (bus.i_req !== 1'b1 || bus.i_addr !== 16'h0040) begin errors++; $display("FAIL jump_J2: got req=%b addr=%h want 1/0040", bus.i_req, bus.i_addr); end
    @(negedge clk);
    checks++; if (bus.c_ack !== 1'b0) begin errors++; $display("FAIL jump_J3: got c_ack=%b want 0", bus.c_ack); end
    @(negedge clk);
    checks++; if (bus.c_ack !== 1'b1 || bus.c_pc !== 16'h0040 || bus.c_rdata !== mem[8'h40]) begin errors++; $display("FAIL jump_J4: got ack=%b pc=%h data=%h want 1/0040/%h", bus.c_ack, bus.c_pc, bus.c_rdata, mem[8'h40]); end
    $display("test_jump done");
  endtask

  task automatic test_end_of_program;
    int base;
    bit busy = 0;
    saw_last = 0; saw_wrap = 0;
    @(posedge clk); #1;
    bus.c_jump = 1'b1; bus.c_jump_addr = 16'h0040; bus.c_req = 1'b1;
    base = pop_count;
    @(posedge clk); #1 bus.c_jump = 1'b0;
    repeat (40) @(negedge clk);
`ifdef I_PREFETCH_WRAP_EN
    checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_fetch: got no fetch of addr 0000 after %0d", MEM_LEN - 1); end
    checks++; if (pop_count - base <= MEM_LEN - 64) begin errors++; $display("FAIL wrap_pops: got %0d pops want more than %0d", pop_count - base, MEM_LEN - 64); end
`else
    checks++; if (pop_count - base != MEM_LEN - 64) begin errors++; $display("FAIL eop_pops: got %0d pops want %0d", pop_count - base, MEM_LEN - 64); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL eop_pending: got %0d undelivered want 0", sb.size()); end
    repeat (10) begin
      @(negedge clk);
      if (bus.i_req || bus.c_ack) busy = 1;
    end
    checks++; if (busy) begin errors++; $display("FAIL eop_idle: got i_req/c_ack activity after end want none"); end
`endif
    $display("test_end_of_program done");
  endtask

  task automatic test_jump_oob;
    bit busy = 0;
    @(posedge clk); #1;
    bus.c_jump = 1'b1; bus.c_jump_addr = 16'd100; bus.c_req = 1'b1;
    @(posedge clk); #1 bus.c_jump = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.i_req || bus.c_ack) busy = 1;
    end
    checks++; if (busy) begin errors++; $display("FAIL jump_oob: got i_req/c_ack activity after jump to 0064 want none"); end
    $display("test_jump_oob done");
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.i_req && !bus.i_ack && bus.i_addr == 16'h2) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_wait: got no fetch of addr 0002 within 30 cycles"); end
    bus.c_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.i_req !== 1'b0 || bus.c_ack !== 1'b0) begin errors++; $display("FAIL rmid_async: got i_req=%b c_ack=%b want 0/0", bus.i_req, bus.c_ack); end
    checks++; if (bus.c_rdata !== 8'h0 || bus.c_pc !== '0) begin errors++; $display("FAIL rmid_head: got data=%h pc=%h want 00/0000", bus.c_rdata, bus.c_pc); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.i_req !== 1'b0) begin errors++; $display("FAIL rmid_c0: got i_req=%b want 0", bus.i_req); end
    @(negedge clk);
    checks++; if (bus.i_req !== 1'b1 || bus.i_addr !== 16'h0) begin errors++; $display("FAIL rmid_c1: got req=%b addr=%h want 1/0000", bus.i_req, bus.i_addr); end
    repeat (2) @(negedge clk);
    checks++; if (bus.c_ack !== 1'b1 || bus.c_pc !== 16'h0 || bus.c_rdata !== 8'h2B) begin errors++; $display("FAIL rmid_c3: got ack=%b pc=%h data=%h want 1/0000/2b", bus.c_ack, bus.c_pc, bus.c_rdata); end
    $display("test_reset_mid done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h2B; mem[1] = 8'h3E; mem[2] = 8'h5B; mem[3] = 8'h5D;
    test_reset();
    test_sequential();
    test_fill_drain();
    test_jump();
    test_end_of_program();
    test_jump_oob();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
